// File: rtl/bg_fetch_sched_pkg.sv
// mcr2_bg_pkg: shared types and defaults for the background fetch scheduler.
//   state_e : scheduler FSM states (IDLE, WR_REQ, RD_REQ, WAIT)
//   rgba_t  : one 32-bit background pixel, {a,b,g,r}
//   DEF_*   : default parameter values
package mcr2_bg_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_RD_REQ = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgba_t;

  localparam int DEF_ADDR_W     = 24;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_PIX_STEP   = 2;
endpackage

// File: rtl/bg_fetch_sched_if.sv
// bg_fetch_sched_if: SDRAM channel-1 request/response bundle.
//   ch_addr  word address        ch_din  16-bit write data
//   ch_req   one-cycle request   ch_rnw  1=read 0=write
//   ch_dout  32-bit read data    ch_ack  one-cycle completion
// master = scheduler side, slave = SDRAM controller side.
interface bg_fetch_sched_if #(
  parameter int ADDR_W = mcr2_bg_pkg::DEF_ADDR_W
);
  logic [ADDR_W-1:0] ch_addr;
  logic [15:0]       ch_din;
  logic              ch_req;
  logic              ch_rnw;
  logic [31:0]       ch_dout;
  logic              ch_ack;

  modport master (output ch_addr, ch_din, ch_req, ch_rnw, input ch_dout, ch_ack);
  modport slave  (input ch_addr, ch_din, ch_req, ch_rnw, output ch_dout, ch_ack);
endinterface

// File: rtl/bg_fetch_sched_pix_fifo.sv
// bg_pix_fifo: small synchronous pixel FIFO.
//   clk/rst  clock, synchronous active-high reset
//   push/din write one pixel (caller guarantees not full)
//   pop      drop head (ignored when empty)
//   flush    empty the FIFO; wins over push/pop in the same cycle
//   head     oldest entry, count = occupancy (0..DEPTH)
module bg_pix_fifo
  import mcr2_bg_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  rgba_t                    din,
  output rgba_t                    head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  rgba_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]     wp_q, rp_q;
  logic [AW:0]       cnt_q;
  logic              do_pop;

  assign do_pop = pop && (cnt_q != '0);
  assign head   = mem_q[rp_q];
  assign count  = cnt_q;

  // Storage needs no reset; pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push)   wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
      case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/bg_fetch_sched.sv
// bg_fetch_sched: shares SDRAM channel 1 between background download writes
// and display-time prefetch reads, and feeds one background pixel per active
// video pixel.
//   clk_sys, reset           clock, synchronous active-high reset
//   dl_active/wr/addr/data   HPS download byte stream (byte address)
//   sdram_ok                 SDRAM fitted
//   ce_pix,hblank,vblank,vs  video timing
//   ch                       SDRAM channel-1 master (bg_fetch_sched_if)
//   bg_enable                sticky "background loaded at least once"
//   pix_rgba, pix_valid      current pixel; valid=0 means FIFO underrun
//   underrun_cnt             only with BG_UNDERRUN_CNT_EN defined: saturating
//                            count of underrun pops
module bg_fetch_sched
  import mcr2_bg_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PIX_STEP   = DEF_PIX_STEP
)(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W:0]   dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              sdram_ok,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vs,
  bg_fetch_sched_if.master  ch,
  output logic              bg_enable,
  output logic [31:0]       pix_rgba,
  output logic              pix_valid
`ifdef BG_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_q, ch_addr_q, pend_addr_q;
  logic [15:0]       ch_din_q, pend_data_q;
  logic [7:0]        even_q;
  logic              pend_q, rnw_q, drop_q, vs_q, dla_q, bg_en_q;
  logic [31:0]       pix_q;
  logic              pix_vld_q;

  logic              restart, post, rd_infl, ack_rd, wr_go, rd_go;
  logic              pix_slot, fifo_push, fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  rgba_t             fifo_head;

  // Frame restart: vs rising edge, or end of a download (stale image data).
  assign restart  = (vs && !vs_q) || (dla_q && !dl_active);
  assign post     = dl_wr && dl_addr[0] && dl_active && sdram_ok;
  // A read counts as in flight from its request cycle until its ack.
  assign rd_infl  = (state_q == ST_RD_REQ) || ((state_q == ST_WAIT) && rnw_q);
  assign ack_rd   = (state_q == ST_WAIT) && ch.ch_ack && rnw_q;
  assign wr_go    = (state_q == ST_IDLE) && pend_q;
  // Only one request outstanding, so in IDLE nothing is in flight and the
  // FIFO count alone decides whether there is room. A restart cycle holds
  // off a new read so it cannot be issued with the pre-restart address.
  assign rd_go    = (state_q == ST_IDLE) && !pend_q && bg_en_q && !dl_active &&
                    (fifo_cnt < CW'(FIFO_DEPTH)) && !restart;
  assign fifo_push  = ack_rd && !drop_q && !restart;
  assign fifo_empty = (fifo_cnt == '0);
  assign pix_slot   = ce_pix && !(hblank || vblank) && bg_en_q;

  bg_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (pix_slot),
    .flush (restart),
    .din   (rgba_t'(ch.ch_dout)),
    .head  (fifo_head),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:              if (wr_go) state_d = ST_WR_REQ;
                            else if (rd_go) state_d = ST_RD_REQ;
      ST_WR_REQ, ST_RD_REQ: state_d = ST_WAIT;
      ST_WAIT:              if (ch.ch_ack) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fetch_q     <= '0;
      ch_addr_q   <= '0;
      ch_din_q    <= '0;
      rnw_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      even_q      <= '0;
      drop_q      <= 1'b0;
      vs_q        <= 1'b0;
      dla_q       <= 1'b0;
      bg_en_q     <= 1'b0;
      pix_q       <= '0;
      pix_vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs;
      dla_q   <= dl_active;
      if (dl_active && sdram_ok) bg_en_q <= 1'b1;

      // Byte pairing: even byte waits, odd byte posts the 16-bit word.
      // A post while a write is still pending overwrites it.
      if (dl_wr && !dl_addr[0]) even_q <= dl_data;
      if (post) begin
        pend_q      <= 1'b1;
        pend_addr_q <= dl_addr[ADDR_W:1];
        pend_data_q <= {dl_data, even_q};
      end else if (wr_go) begin
        pend_q <= 1'b0;
      end

      if (wr_go) begin
        ch_addr_q <= pend_addr_q;
        ch_din_q  <= pend_data_q;
        rnw_q     <= 1'b0;
      end else if (rd_go) begin
        ch_addr_q <= fetch_q;
        rnw_q     <= 1'b1;
      end

      if (restart)    fetch_q <= '0;
      else if (rd_go) fetch_q <= fetch_q + ADDR_W'(PIX_STEP);

      // An ack landing on the restart cycle belongs to the old frame and is
      // discarded by the flush, so only later acks need the drop flag.
      if (restart && rd_infl && !ack_rd) drop_q <= 1'b1;
      else if (ack_rd)                   drop_q <= 1'b0;

      if (pix_slot) begin
        pix_q     <= fifo_empty ? 32'h0 : fifo_head;
        pix_vld_q <= !fifo_empty;
      end
    end
  end

  assign ch.ch_req  = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign ch.ch_rnw  = rnw_q;
  assign ch.ch_addr = ch_addr_q;
  assign ch.ch_din  = ch_din_q;
  assign bg_enable  = bg_en_q;
  assign pix_rgba   = pix_q;
  assign pix_valid  = pix_vld_q;

`ifdef BG_UNDERRUN_CNT_EN
  logic [15:0] urun_q;
  always_ff @(posedge clk_sys) begin
    if (reset)                                      urun_q <= '0;
    else if (pix_slot && fifo_empty && urun_q != 16'hFFFF) urun_q <= urun_q + 1'b1;
  end
  assign underrun_cnt = urun_q;
`endif
endmodule

// File: tb/tb_bg_fetch_sched.sv
// Bench for bg_fetch_sched: SDRAM responder with programmable ack delay,
// write scoreboard, pixel scoreboard and fetch-address model.
module tb_bg_fetch_sched;
  import mcr2_bg_pkg::*;
  localparam int AW = 24;

  logic clk_sys = 1'b0, reset = 1'b1;
  logic dl_active = 1'b0, dl_wr = 1'b0, sdram_ok = 1'b0, vs = 1'b0;
  logic ce_pix = 1'b0, hblank = 1'b0, vblank = 1'b1;
  logic [AW:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        bg_enable, pix_valid;
  logic [31:0] pix_rgba;
`ifdef BG_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  bg_fetch_sched_if #(.ADDR_W(AW)) ch();

  bg_fetch_sched #(.ADDR_W(AW), .FIFO_DEPTH(4), .PIX_STEP(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .sdram_ok(sdram_ok), .ce_pix(ce_pix),
    .hblank(hblank), .vblank(vblank), .vs(vs), .ch(ch), .bg_enable(bg_enable),
    .pix_rgba(pix_rgba), .pix_valid(pix_valid)
`ifdef BG_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix_of(input logic [AW-1:0] a);
    return {8'hA5, a};
  endfunction

  // scoreboards / model state
  logic [31:0]      pq[$];
  logic [AW+15:0]   wq[$];
  int               ack_dly = 2;
  int               req_cnt = 0, rd_cnt = 0, urun_cnt = 0, dut_urun = 0;
  logic             last_rnw = 1'b0;
  logic [AW-1:0]    last_addr = '0;
  logic [7:0]       tb_even = '0;
  int               vmode = 0;

  // SDRAM responder + model, sampling pre-edge inputs at posedge, checking #1 after.
  initial begin
    logic [AW-1:0] exp_fetch, out_addr, s_addr;
    logic [15:0]   s_din;
    logic [AW+15:0] w;
    logic out_vld, out_rnw, drop, vs_p, dla_p, exp_en;
    logic s_rst, s_req, s_rnw, s_ack, s_pop, s_vs, s_dla, s_ok, s_cmp, rst_ev;
    logic [31:0] e;
    int tmr;
    exp_fetch = '0; out_addr = '0; out_vld = 0; out_rnw = 0; drop = 0;
    vs_p = 0; dla_p = 0; exp_en = 0; tmr = 0;
    ch.ch_ack = 1'b0; ch.ch_dout = '0;
    forever begin
      @(posedge clk_sys);
      s_rst = reset; s_req = ch.ch_req; s_rnw = ch.ch_rnw; s_addr = ch.ch_addr;
      s_din = ch.ch_din; s_ack = ch.ch_ack; s_pop = ce_pix && !(hblank || vblank);
      s_vs = vs; s_dla = dl_active; s_ok = sdram_ok;
      #1;
      if (s_rst) begin
        pq.delete(); exp_fetch = '0; out_vld = 0; drop = 0;
        vs_p = 0; dla_p = 0; exp_en = 0; ch.ch_ack = 1'b0;
        continue;
      end
      rst_ev = (s_vs && !vs_p) || (dla_p && !s_dla);
      // pop sees the queue before this edge's push
      if (s_pop && exp_en) begin
        if (!pix_valid) dut_urun++;
        if (pq.size() > 0) begin
          e = pq.pop_front();
          chk("pix_rgba", pix_rgba, e);
          chk("pix_valid", pix_valid, 1);
        end else begin
          urun_cnt++;
          chk("urun_rgba", pix_rgba, 0);
          chk("urun_valid", pix_valid, 0);
        end
      end
      s_cmp = s_ack && out_vld;
      if (s_cmp) begin
        if (out_rnw && !drop) pq.push_back(pix_of(out_addr));
        if (out_rnw) drop = 0;
        out_vld = 0;
      end
      if (s_req) begin
        chk("req_overlap", out_vld, 0);
        req_cnt++; last_rnw = s_rnw; last_addr = s_addr;
        if (s_rnw) begin
          chk("rd_addr", s_addr, exp_fetch);
          exp_fetch = exp_fetch + AW'(2);
          rd_cnt++;
        end else if (wq.size() == 0) begin
          chk("wr_unexpected", wq.size(), 1);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", s_addr, w[AW+15:16]);
          chk("wr_data", s_din, w[15:0]);
        end
        out_vld = 1; out_rnw = s_rnw; out_addr = s_addr; tmr = ack_dly;
      end
      if (rst_ev) begin
        pq.delete(); exp_fetch = '0;
        if (out_vld && out_rnw) drop = 1;
      end
      vs_p = s_vs; dla_p = s_dla;
      if (s_dla && s_ok) exp_en = 1;
      ch.ch_ack = 1'b0;
      if (out_vld) begin
        tmr--;
        if (tmr <= 0) begin ch.ch_ack = 1'b1; ch.ch_dout = pix_of(out_addr); end
      end
    end
  end

  // video timing: 0 = vblank, 1 = 4 active pixels per 24-clk line, 2 = all active
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk_sys);
      case (vmode)
        0: begin ce_pix = 0; hblank = 0; vblank = 1; end
        1: begin ce_pix = ph[0]; hblank = (ph >= 8); vblank = 0; ph = (ph + 1) % 24; end
        default: begin ce_pix = 1; hblank = 0; vblank = 0; end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic dl_byte(input logic [AW:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    dl_wr = 1; dl_addr = a; dl_data = d;
    if (!a[0]) tb_even = d;
    else if (dl_active && sdram_ok) wq.push_back({a[AW:1], d, tb_even});
    @(negedge clk_sys);
    dl_wr = 0;
    tick(2);
  endtask

  task automatic vs_pulse();
    @(negedge clk_sys); vs = 1;
    tick(2); vs = 0;
  endtask

  task automatic wait_req(input string tag, input int maxc);
    int c0, n;
    c0 = req_cnt; n = 0;
    while (req_cnt == c0 && n < maxc) begin @(negedge clk_sys); n++; end
    if (req_cnt == c0) chk(tag, req_cnt, c0 + 1);
  endtask

  task automatic wait_rd_at(input logic [AW-1:0] a, input int maxc);
    int n;
    n = 0;
    while (!(last_rnw && last_addr == a) && n < maxc) begin @(negedge clk_sys); n++; end
    chk("wait_rd_addr", last_addr, a);
  endtask

  initial begin
    int u0;
    // reset state
    tick(3);
    chk("rst_bg_enable", bg_enable, 0);
    chk("rst_pix_rgba", pix_rgba, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_ch_req", ch.ch_req, 0);
    chk("rst_ch_rnw", ch.ch_rnw, 0);
    chk("rst_ch_addr", ch.ch_addr, 0);
    chk("rst_ch_din", ch.ch_din, 0);
    reset = 0;

    // download without SDRAM: nothing must happen
    dl_active = 1;
    dl_byte(0, 8'h11); dl_byte(1, 8'h22); dl_byte(2, 8'h33); dl_byte(3, 8'h44);
    dl_active = 0;
    tick(10);
    chk("nosdram_bg_enable", bg_enable, 0);
    chk("nosdram_reqs", req_cnt, 0);
    chk("nosdram_pix", pix_rgba, 0);

    // real download: two paired writes, no reads
    sdram_ok = 1; dl_active = 1;
    tick(2);
    chk("dl_bg_enable", bg_enable, 1);
    dl_byte(0, 8'h11); dl_byte(1, 8'h22); dl_byte(2, 8'h33); dl_byte(3, 8'h44);
    tick(10);
    chk("dl_wr_reqs", req_cnt, 2);
    chk("dl_no_reads", rd_cnt, 0);
    chk("dl_wq_drained", wq.size(), 0);
    chk("dl_last_rnw", last_rnw, 0);
    dl_active = 0;

    // prefetch fills the FIFO and stops at depth
    tick(30);
    chk("fill_reads", rd_cnt, 4);
    // streaming: 4 active pixels/line, ack 2 clk -> never empty
    u0 = dut_urun;
    vmode = 1;
    tick(24 * 8);
    chk("stream_underruns", dut_urun - u0, 0);
    chk("stream_bg_enable", bg_enable, 1);

    // slow SDRAM, every clock active -> underruns
    ack_dly = 20; u0 = dut_urun;
    vmode = 2;
    tick(80);
    chk("slow_underruns_seen", (dut_urun - u0) > 0, 1);
`ifdef BG_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, urun_cnt);
`endif

    // vs rise while read at addr 6 in flight: data dropped, restart at 0
    vmode = 0;
    vs_pulse();
    wait_rd_at(6, 300);
    vs_pulse();
    wait_req("restart_req_timeout", 100);
    chk("restart_addr", last_addr, 0);
    chk("restart_rnw", last_rnw, 1);
    ack_dly = 2;
    tick(100);
    vmode = 1;
    tick(24 * 3);

    // pending write posted while a read is outstanding goes out first
    vmode = 0;
    tick(10);
    ack_dly = 20;
    vs_pulse();
    wait_req("prio_rd_timeout", 60);
    dl_active = 1;
    dl_byte(10, 8'h55); dl_byte(11, 8'h66);
    dl_active = 0;
    wait_req("prio_wr_timeout", 60);
    chk("wr_prio_rnw", last_rnw, 0);
    chk("wr_prio_addr", last_addr, 5);
    tick(60);
    chk("end_wq_empty", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
